// File: rtl/csel_pkg.sv
// Shared types and constants for the 2-bit-per-cycle carry-select adder.
package csel_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int SLICE_W = 2;

  // Slice sum bit positions: the lower-position sum arrives on bit 1.
  localparam int LO_POS = 1;
  localparam int HI_POS = 0;

endpackage

// File: rtl/csel_carry_pick.sv
// Carry-select mux: picks one of the two precomputed slice result sets.
module csel_carry_pick
  import csel_pkg::*;
(
  input  logic               carry,
  input  logic [SLICE_W-1:0] sum_c1,
  input  logic               cout_c1,
  input  logic [SLICE_W-1:0] sum_c0,
  input  logic               cout_c0,
  output logic [SLICE_W-1:0] sum_sel,
  output logic               cout_sel
);

  assign sum_sel  = carry ? sum_c1  : sum_c0;
  assign cout_sel = carry ? cout_c1 : cout_c0;

endmodule

// File: rtl/csel_serial_adder.sv
// Serial carry-select adder controller: one external 2-bit slice per clock.
module csel_serial_adder
  import csel_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = (WIDTH / 2 > 1) ? $clog2(WIDTH / 2) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               cin,
  output logic [SLICE_W-1:0] slice_x,
  output logic [SLICE_W-1:0] slice_y,
  input  logic [SLICE_W-1:0] slice_sum_c1,
  input  logic               slice_cout_c1,
  input  logic [SLICE_W-1:0] slice_sum_c0,
  input  logic               slice_cout_c0,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   sum,
  output logic               cout
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH / 2 - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic [CNT_W:0]     off;
  logic [SLICE_W-1:0] pick_sum;
  logic               pick_cout;

  assign off = {idx_q, 1'b0};

  assign slice_x = (state_q == RUN) ? a_q[off +: SLICE_W] : '0;
  assign slice_y = (state_q == RUN) ? b_q[off +: SLICE_W] : '0;

  csel_carry_pick u_pick (
    .carry    (carry_q),
    .sum_c1   (slice_sum_c1),
    .cout_c1  (slice_cout_c1),
    .sum_c0   (slice_sum_c0),
    .cout_c0  (slice_cout_c0),
    .sum_sel  (pick_sum),
    .cout_sel (pick_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Slice returns sums in swapped order; restore position order here.
        sum_d[off +: SLICE_W] = {pick_sum[HI_POS], pick_sum[LO_POS]};
        carry_d = pick_cout;
        if (idx_q == LAST) begin
          cout_d  = pick_cout;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_csel_serial_adder.sv
// Randomized check of csel_serial_adder against plain A+B+cin arithmetic.
module tb_csel_serial_adder;

  localparam int W = 16;
  localparam int N_RND = 1000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic [1:0]   slice_x, slice_y;
  logic [1:0]   slice_sum_c1, slice_sum_c0;
  logic         slice_cout_c1, slice_cout_c0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  csel_serial_adder #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .a             (a),
    .b             (b),
    .cin           (cin),
    .slice_x       (slice_x),
    .slice_y       (slice_y),
    .slice_sum_c1  (slice_sum_c1),
    .slice_cout_c1 (slice_cout_c1),
    .slice_sum_c0  (slice_sum_c0),
    .slice_cout_c0 (slice_cout_c0),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .sum           (sum),
    .cout          (cout)
  );

  // Behavioural slice: 2-bit add, lower-position sum reported on bit 1.
  logic [2:0] s0, s1;
  always_comb begin
    s0 = {1'b0, slice_x} + {1'b0, slice_y};
    s1 = {1'b0, slice_x} + {1'b0, slice_y} + 3'd1;
    slice_sum_c0  = {s0[0], s0[1]};
    slice_cout_c0 = s0[2];
    slice_sum_c1  = {s1[0], s1[1]};
    slice_cout_c1 = s1[2];
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] ref_add(input logic [W-1:0] x,
                                         input logic [W-1:0] y,
                                         input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic tc, input int hold);
    logic [W:0] e;
    int n;
    e = ref_add(ta, tb_, tc);
    @(negedge clk);
    chk("idle_ready", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    a         = ta;
    b         = tb_;
    cin       = tc;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'd8);
    for (int i = 0; i < hold; i++) begin
      chk("hold", 32'({out_valid, in_ready, cout, sum}), 32'({2'b10, e}));
      @(negedge clk);
    end
    chk("result", 32'({cout, sum}), 32'(e));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("release", 32'({out_valid, in_ready}), 32'b01);
  endtask

  logic [W:0] exp_q[$];
  logic [W:0] e;
  int sent, recv, cyc;
  logic acc_last;

  initial begin
    #1;
    chk("rst_state", 32'({out_valid, in_ready, cout, sum}), 32'({2'b01, 17'd0}));
    chk("rst_slice", 32'({slice_x, slice_y}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'h0003, 16'h0001, 1'b0, 0);
    chk("dir_0004", 32'({cout, sum}), 32'h0_0004);
    run_op(16'hFFFF, 16'h0001, 1'b0, 0);
    chk("dir_ripple", 32'({cout, sum}), 32'h1_0000);
    run_op(16'h0000, 16'h0000, 1'b1, 0);
    chk("dir_cin", 32'({cout, sum}), 32'h0_0001);
    run_op(16'h1234, 16'h4321, 1'b0, 5);
    chk("dir_5555", 32'({cout, sum}), 32'h0_5555);

    // Abort mid-run at slice index 3.
    @(negedge clk);
    in_valid = 1'b1;
    a = 16'hABCD;
    b = 16'h1111;
    cin = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("slice3_x", 32'(slice_x), 32'(2'b11));
    chk("slice3_y", 32'(slice_y), 32'(2'b00));
    rst_n = 1'b0;
    #1;
    chk("abort_out", 32'({out_valid, in_ready, cout, sum}), 32'({2'b01, 17'd0}));
    chk("abort_slice", 32'({slice_x, slice_y}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("no_ghost", 32'({out_valid, in_ready}), 32'b01);
    run_op(16'h00FF, 16'h0001, 1'b0, 0);
    chk("dir_0100", 32'({cout, sum}), 32'h0_0100);

    // Random traffic with random backpressure; decisions made at negedge.
    sent = 0;
    recv = 0;
    cyc = 0;
    acc_last = 1'b0;
    while (recv < N_RND && cyc < 50000) begin
      @(negedge clk);
      cyc++;
      if (acc_last) in_valid = 1'b0;
      acc_last = 1'b0;
      if (!in_valid && sent < N_RND && ($urandom % 4 != 0)) begin
        in_valid = 1'b1;
        a = W'($urandom);
        b = W'($urandom);
        cin = 1'($urandom);
      end
      out_ready = 1'($urandom);
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_add(a, b, cin));
        sent++;
        acc_last = 1'b1;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("rnd_extra", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rnd_result", 32'({cout, sum}), 32'(e));
        end
        recv++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("rnd_count", 32'(recv), 32'(N_RND));
    chk("rnd_sent", 32'(sent), 32'(N_RND));
    chk("rnd_left", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
